fifo_wptr_full: RTL
===================

# fifo_wptr_full

Write-side pointer and status controller for the asynchronous FIFO, running entirely in the write clock domain. It owns the binary and Gray write pointers, drives the write address and write-enable qualification into the FIFO memory, and synchronises the read-domain Gray pointer. From that synchronised pointer it produces full, almost-full, fill level and a sticky overflow flag. It sits directly upstream of the FIFO memory and mirrors the read-side controller.

## Interface
Parameters:
- DEPTH, 8, number of memory entries; must equal 2**PTR_WIDTH.
- PTR_WIDTH, 3, memory address width; pointers are PTR_WIDTH+1 bits.
- AFULL_TH, 6, almost_full threshold in entries; legal range 1..DEPTH.

Ports:
- wclk  in  1  write clock; the only clock; all state on rising edge.
- wrst_n  in  1  reset; asynchronous, active-low.
- w_en  in  1  write request from producer.
- g_rptr_async  in  PTR_WIDTH+1  Gray read pointer, registered in the rclk domain.
- clr_ovf  in  1  clears the overflow flag.
- wr_ok  out  1  write accepted this cycle, w_en & !full; memory write enable.
- b_wptr  out  PTR_WIDTH+1  binary write pointer; low PTR_WIDTH bits are the memory address.
- g_wptr  out  PTR_WIDTH+1  Gray write pointer, to be synchronised by the read side.
- full  out  1  FIFO full (registered).
- almost_full  out  1  wlevel >= AFULL_TH (registered).
- wlevel  out  PTR_WIDTH+1  occupancy as seen from the write side, 0..DEPTH (registered).
- overflow  out  1  sticky: a write was attempted while full.

## Operation
- Reset (wrst_n=0, asynchronous): b_wptr, g_wptr, both synchroniser stages, full, almost_full, wlevel and overflow all go to 0.
- Synchroniser: g_rptr_async passes through two wclk flops to give rptr_s. No other logic touches g_rptr_async.
- Pointer update:
  - b_wptr_next = b_wptr + wr_ok, modulo 2**(PTR_WIDTH+1).
  - g_wptr_next = b_wptr_next ^ (b_wptr_next >> 1).
  - Both are registered on wclk.
- Full:
  - full_next = (g_wptr_next == {~rptr_s[PTR_WIDTH:PTR_WIDTH-1], rptr_s[PTR_WIDTH-2:0]}).
  - full is registered.
  - For PTR_WIDTH=1, invert both bits.
- Level:
  - wlevel_next = b_wptr_next − gray2bin(rptr_s), modulo 2**(PTR_WIDTH+1).
  - almost_full_next = (wlevel_next >= AFULL_TH).
  - Both are registered.
- Status is pessimistic: the read pointer is stale, so full and wlevel may over-report. They must never under-report.
- Overflow:
  - Sets on any edge where w_en & full.
  - Clears on clr_ovf.
  - If both occur on the same edge, set wins.
- A write while full is dropped: the pointers hold and wr_ok=0.
- Wrap-around: pointers wrap from 2**(PTR_WIDTH+1)−1 to 0 without special handling. The MSB toggle distinguishes full from empty.

## Timing
- wr_ok is combinational from w_en and the full register, so it is valid in the same cycle.
- Effects of an accepted write, all visible after the same wclk edge:
  - b_wptr and g_wptr advance.
  - full, almost_full and wlevel update.
- Read progress latency: a change on g_rptr_async that is stable before wclk edge N is reflected in full, wlevel and almost_full after edge N+2. That is two synchroniser edges plus the status register, which captures rptr_s on the edge after it updates.
- g_wptr changes by exactly one bit per accepted write and is driven directly from a flop (glitch-free for CDC).
- Reset mid-operation: outputs clear immediately, without a clock edge. The first write after release uses address 0.

## Structure
- Package fifo_pkg:
  - bin2gray and gray2bin functions, parameterised on width.
  - Shared pointer-width localparam, reused by the read-side controller.
- Sub-module sync_2ff:
  - Generic WIDTH-bit two-flop synchroniser.
  - Clock wclk, asynchronous active-low reset to 0.
  - Reused for the wptr→rclk direction.
- Top level holds the pointer registers, full/level/almost_full logic and the overflow flag.

## Test plan
- Reset, then hold g_rptr_async=0 and write 8 times: b_wptr steps 1..8, g_wptr ends at 4'b1100, full=1 after the 8th edge, wlevel=8, almost_full=1 from the 6th write.
- While full, assert w_en: wr_ok=0, b_wptr stays 8, overflow=1. Pulse clr_ovf → overflow=0 next edge. Assert w_en while full together with clr_ovf → overflow stays 1.
- From full, set g_rptr_async=4'b0001 before edge N: full stays 1 through edge N+1, drops after edge N+2, wlevel=7, almost_full=1.
- Wrap: run 20 writes with g_rptr_async tracking gray(b_wptr−2) and stable ≥3 edges before each write: b_wptr wraps 15→0 and g_wptr goes 4'b1000→4'b0000. full never asserts, and wlevel settles to 2 three edges after each read-pointer update.
- Drop wrst_n asynchronously at wlevel=5: all outputs read 0 before the next wclk edge. After release, the first write gives b_wptr=1.
- AFULL_TH=8, DEPTH=8: almost_full and full assert on the same edge.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared pointer helpers for the async FIFO write- and read-side controllers.
// Gray/binary conversion works on zero-extended 32-bit values, so any pointer width up to 32 is handled.
package fifo_pkg;

  localparam int FIFO_PTR_WIDTH = 3;
  localparam int FIFO_DEPTH     = 1 << FIFO_PTR_WIDTH;
  localparam int CONV_W         = 32;

  // Zero high bits do not disturb the XOR chain, so callers zero-extend and truncate.
  function automatic logic [CONV_W-1:0] bin2gray(input logic [CONV_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [CONV_W-1:0] gray2bin(input logic [CONV_W-1:0] g);
    logic [CONV_W-1:0] b;
    b[CONV_W-1] = g[CONV_W-1];
    for (int i = CONV_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for Gray pointers crossing into the wclk domain.
// Latency two wclk edges; no backpressure, samples every edge.
module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             wclk,
  input  logic             wrst_n,
  input  logic [WIDTH-1:0] d_async,
  output logic [WIDTH-1:0] q_sync
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d_async;
    sync_d = meta_q;
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q_sync = sync_q;

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-side pointer/status controller of the async FIFO: pointers, full, level, almost_full, overflow.
// Status registered one edge after a write; read progress seen after two sync edges plus the status flop.
module fifo_wptr_full
  import fifo_pkg::*;
#(
  parameter int DEPTH     = FIFO_DEPTH,
  parameter int PTR_WIDTH = FIFO_PTR_WIDTH,
  parameter int AFULL_TH  = 6
) (
  input  logic               wclk,
  input  logic               wrst_n,
  input  logic               w_en,
  input  logic [PTR_WIDTH:0] g_rptr_async,
  input  logic               clr_ovf,
  output logic               wr_ok,
  output logic [PTR_WIDTH:0] b_wptr,
  output logic [PTR_WIDTH:0] g_wptr,
  output logic               full,
  output logic               almost_full,
  output logic [PTR_WIDTH:0] wlevel,
  output logic               overflow
);

  localparam int PW = PTR_WIDTH + 1;
  // Full means the write pointer sits one lap ahead: top two Gray bits differ, rest equal.
  localparam logic [PW-1:0]   FULL_MASK  = PW'(3) << (PW - 2);
  localparam logic [31:0]     AFULL_TH_U = 32'(AFULL_TH);

  logic [PW-1:0] rptr_s;

  logic [PW-1:0] b_wptr_q, b_wptr_d;
  logic [PW-1:0] g_wptr_q, g_wptr_d;
  logic [PW-1:0] wlevel_q, wlevel_d;
  logic          full_q, full_d;
  logic          almost_full_q, almost_full_d;
  logic          overflow_q, overflow_d;
  logic [PW-1:0] b_rptr_s;

  sync_2ff #(
    .WIDTH (PW)
  ) u_rptr_sync (
    .wclk    (wclk),
    .wrst_n  (wrst_n),
    .d_async (g_rptr_async),
    .q_sync  (rptr_s)
  );

  assign wr_ok = w_en & ~full_q;

  always_comb begin
    b_rptr_s      = PW'(gray2bin(CONV_W'(rptr_s)));
    b_wptr_d      = b_wptr_q + PW'(wr_ok);
    g_wptr_d      = PW'(bin2gray(CONV_W'(b_wptr_d)));
    full_d        = (g_wptr_d == (rptr_s ^ FULL_MASK));
    wlevel_d      = b_wptr_d - b_rptr_s;
    almost_full_d = (32'(wlevel_d) >= AFULL_TH_U);
    overflow_d    = overflow_q;
    if (clr_ovf) begin
      overflow_d = 1'b0;
    end
    if (w_en && full_q) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      b_wptr_q      <= '0;
      g_wptr_q      <= '0;
      wlevel_q      <= '0;
      full_q        <= 1'b0;
      almost_full_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      b_wptr_q      <= b_wptr_d;
      g_wptr_q      <= g_wptr_d;
      wlevel_q      <= wlevel_d;
      full_q        <= full_d;
      almost_full_q <= almost_full_d;
      overflow_q    <= overflow_d;
    end
  end

  assign b_wptr      = b_wptr_q;
  assign g_wptr      = g_wptr_q;
  assign full        = full_q;
  assign almost_full = almost_full_q;
  assign wlevel      = wlevel_q;
  assign overflow    = overflow_q;

endmodule
